// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared definitions for the bit-serial ALU.
//   - op encodings (OP_ADD, OP_SUB, OP_POPCNT, OP_RSVD)
//   - FSM state enum (IDLE, RUN, DONE)
//   - cnt_width(): counter width able to hold 0..width
package serial_alu_pkg;

   localparam int unsigned OP_W = 2;

   localparam logic [OP_W-1:0] OP_ADD    = 2'b00;
   localparam logic [OP_W-1:0] OP_SUB    = 2'b01;
   localparam logic [OP_W-1:0] OP_POPCNT = 2'b10;
   localparam logic [OP_W-1:0] OP_RSVD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count from 0 up to and including width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_alu_if.sv
// serial_alu_if: request/response bundle of the bit-serial ALU.
//   master: start, op, a, b, cin out; busy, done, result, cout, ovf in
//   slave : the reverse (the ALU itself)
interface serial_alu_if
   import serial_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, op, a, b, cin,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, op, a, b, cin,
      output busy, done, result, cout, ovf
   );

endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   a, b, c : addend bits and carry-in
//   s       : sum bit
//   c_out   : carry-out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic c_out,
   output logic s
);

   assign s     = a ^ b ^ c;
   assign c_out = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ADD / SUB / POPCNT unit, one bit per clock, LSB first.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : serial_alu_if slave port
//              start/op/a/b/cin sampled when idle or done;
//              busy high for WIDTH cycles, done pulses once with result/cout/ovf
module serial_alu
   import serial_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_alu_if.slave   bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  a_sh;
   logic [WIDTH-1:0]  b_sh;
   logic [WIDTH-2:0]  sum_sh;
   logic              carry;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     ones;

   logic              fa_s;
   logic              fa_c;
   logic [WIDTH-1:0]  sum_nxt;
   logic [CW-1:0]     ones_nxt;

   full_adder u_fa (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c     (carry),
      .c_out (fa_c),
      .s     (fa_s)
   );

   // Sum bits enter at the MSB; after WIDTH cycles sum_nxt is the full result.
   assign sum_nxt  = {fa_s, sum_sh};
   assign ones_nxt = ones + CW'(a_sh[0]);

   // FSM, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= OP_ADD;
         a_sh       <= '0;
         b_sh       <= '0;
         sum_sh     <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         ones       <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.cout   <= 1'b0;
         bus.ovf    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  op_q     <= bus.op;
                  a_sh     <= bus.a;
                  // SUB is a + ~b + 1: invert b here, carry-in of 1 below.
                  b_sh     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                  carry    <= (bus.op == OP_ADD) ? bus.cin : (bus.op == OP_SUB);
                  sum_sh   <= '0;
                  cnt      <= '0;
                  ones     <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_nxt[WIDTH-1:1];
               carry  <= fa_c;
               cnt    <= cnt + CW'(1);
               ones   <= ones_nxt;
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
                  case (op_q)
                     OP_ADD, OP_SUB: begin
                        bus.result <= sum_nxt;
                        bus.cout   <= fa_c;
                        // carry still holds the carry into the MSB here.
                        bus.ovf    <= carry ^ fa_c;
                     end
                     OP_POPCNT: begin
                        bus.result <= WIDTH'(ones_nxt);
                        bus.cout   <= 1'b0;
                        bus.ovf    <= 1'b0;
                     end
                     default: begin
                        bus.result <= '0;
                        bus.cout   <= 1'b0;
                        bus.ovf    <= 1'b0;
                     end
                  endcase
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
